// File: rtl/key_entry_fsm_pkg.sv
// key_entry_fsm_pkg
// Shared definitions for the calculator entry core: key codes coming from
// keypad_driver, operator encodings, display words for segment_driver,
// FSM state encodings and the displayable result range.
package key_entry_fsm_pkg;

    // Entry and range limits
    localparam int CALC_MAX_DIGITS = 5;
    localparam int CALC_RES_MAX    = 999999;
    localparam int CALC_RES_MIN    = -99999;

    // Key codes (0x00..0x09 are digits)
    localparam logic [4:0] KEY_DIGIT_MAX = 5'h09;
    localparam logic [4:0] KEY_PLUS      = 5'h0A;
    localparam logic [4:0] KEY_MINUS     = 5'h0B;
    localparam logic [4:0] KEY_MUL       = 5'h0C;
    localparam logic [4:0] KEY_DIV       = 5'h0D;
    localparam logic [4:0] KEY_MOD       = 5'h0E;
    localparam logic [4:0] KEY_EQUAL     = 5'h0F;
    localparam logic [4:0] KEY_CLEAR     = 5'h10;
    localparam logic [4:0] KEY_IDLE      = 5'h1F;

    // Operator encodings; the value is also the nibble shown on the display
    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_MOD  = 3'd5;

    localparam logic [31:0] DISP_ERR = 32'h00EE_0000;

    // FSM states
    localparam logic [2:0] S_A   = 3'd0;
    localparam logic [2:0] S_OP  = 3'd1;
    localparam logic [2:0] S_B   = 3'd2;
    localparam logic [2:0] S_RES = 3'd3;
    localparam logic [2:0] S_ERR = 3'd4;

    // Operator display word: PLUS -> 0x0010_0000 ... MOD -> 0x0050_0000
    function automatic logic [31:0] op_disp(input logic [2:0] op);
        return {9'h000, op, 20'h00000};
    endfunction

    // Operator keys 0x0A..0x0E map onto OP_ADD..OP_MOD
    function automatic logic [2:0] key_to_op(input logic [4:0] key);
        logic [4:0] t;
        t = key - 5'd9;
        return t[2:0];
    endfunction

endpackage

// File: rtl/key_entry_fsm_calc_alu.sv
// calc_alu
// Combinational arithmetic for the calculator: R = A op B.
// Ports:
//   i_a, i_b   : signed 32-bit operands
//   i_op       : operator (OP_ADD..OP_MOD)
//   o_r        : signed 32-bit result (low bits of the 40-bit working value)
//   o_err_flag : divide/modulo by zero, or result outside [RES_MIN, RES_MAX]
module calc_alu
    import key_entry_fsm_pkg::*;
#(
    parameter int RES_MAX = CALC_RES_MAX,
    parameter int RES_MIN = CALC_RES_MIN
) (
    input  logic signed [31:0] i_a,
    input  logic signed [31:0] i_b,
    input  logic [2:0]         i_op,
    output logic signed [31:0] o_r,
    output logic               o_err_flag
);

    localparam logic signed [39:0] LIM_MAX = 40'(RES_MAX);
    localparam logic signed [39:0] LIM_MIN = 40'(RES_MIN);

    logic signed [39:0] w_a40;
    logic signed [39:0] w_b40;
    logic signed [39:0] w_wide;
    logic               w_div_zero;

    assign w_div_zero = ((i_op == OP_DIV) || (i_op == OP_MOD)) && (i_b == 32'sd0);

    // Working at 40 bits keeps the product of two in-range operands exact,
    // so the range check sees the true value rather than a wrapped one.
    assign w_a40 = {{8{i_a[31]}}, i_a};
    // A zero divisor is swapped for 1 so the divider never sees 0; the
    // result is discarded anyway because w_div_zero raises the error.
    assign w_b40 = w_div_zero ? 40'sd1 : {{8{i_b[31]}}, i_b};

    // Signed / and % truncate toward zero, remainder follows the dividend.
    always_comb begin
        w_wide = '0;
        case (i_op)
            OP_ADD:  w_wide = w_a40 + w_b40;
            OP_SUB:  w_wide = w_a40 - w_b40;
            OP_MUL:  w_wide = w_a40 * w_b40;
            OP_DIV:  w_wide = w_a40 / w_b40;
            OP_MOD:  w_wide = w_a40 % w_b40;
            default: w_wide = '0;
        endcase
    end

    assign o_r        = w_wide[31:0];
    assign o_err_flag = w_div_zero || (w_wide > LIM_MAX) || (w_wide < LIM_MIN);

endmodule

// File: rtl/key_entry_fsm.sv
// key_entry_fsm
// Calculator entry/evaluation core. Detects key presses on the eBCD code
// from keypad_driver, accumulates operands, evaluates strictly left to
// right and drives the signed display word for segment_driver.
// Ports:
//   sw_clk       : clock (keypad clock domain)
//   rst          : asynchronous active-high reset
//   eBCD         : 5-bit key code, 5'h1F = no key
//   fnd_serial   : signed 32-bit display word (number, operator or error code)
//   result_valid : one-cycle pulse when a result is loaded
//   err          : high while in the error state
//   o_dbg_state  : current FSM state (S_A/S_OP/S_B/S_RES/S_ERR)
module key_entry_fsm
    import key_entry_fsm_pkg::*;
#(
    parameter int MAX_DIGITS = CALC_MAX_DIGITS,
    parameter int RES_MAX    = CALC_RES_MAX,
    parameter int RES_MIN    = CALC_RES_MIN
) (
    input  logic        sw_clk,
    input  logic        rst,
    input  logic [4:0]  eBCD,
    output logic [31:0] fnd_serial,
    output logic        result_valid,
    output logic        err,
    output logic [2:0]  o_dbg_state
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic [4:0]         r_ebcd_prev;
    logic [2:0]         r_state;
    logic signed [31:0] r_a;
    logic signed [31:0] r_b;
    logic [2:0]         r_op;
    logic [CW-1:0]      r_count;
    logic [31:0]        r_fnd;
    logic               r_result_valid;

    logic               w_key_event;
    logic               w_is_digit;
    logic               w_is_op;
    logic [2:0]         w_key_op;
    logic signed [31:0] w_digit;
    logic               w_digit_nz;
    logic signed [31:0] w_acc_src;
    logic signed [31:0] w_acc;
    logic               w_count_ok;
    logic [CW-1:0]      w_acc_count;
    logic signed [31:0] w_alu_r;
    logic               w_alu_err;

    // A press is the first cycle the code leaves idle; holding a key
    // produces nothing more until it returns to idle.
    assign w_key_event = (r_ebcd_prev == KEY_IDLE) && (eBCD != KEY_IDLE);

    assign w_is_digit = (eBCD <= KEY_DIGIT_MAX);
    assign w_is_op    = (eBCD >= KEY_PLUS) && (eBCD <= KEY_MOD);
    assign w_key_op   = key_to_op(eBCD);
    assign w_digit    = {27'd0, eBCD};
    assign w_digit_nz = (eBCD != 5'd0);

    // Shared accumulator: S_A builds A, S_B builds B. The digit count only
    // advances once the operand is non-zero, so leading zeros are free.
    assign w_acc_src   = (r_state == S_A) ? r_a : r_b;
    assign w_acc       = (w_acc_src * 32'sd10) + w_digit;
    assign w_count_ok  = (int'(r_count) < MAX_DIGITS);
    assign w_acc_count = (w_acc != 32'sd0) ? (r_count + 1'b1) : r_count;

    calc_alu #(
        .RES_MAX (RES_MAX),
        .RES_MIN (RES_MIN)
    ) u_alu (
        .i_a        (r_a),
        .i_b        (r_b),
        .i_op       (r_op),
        .o_r        (w_alu_r),
        .o_err_flag (w_alu_err)
    );

    always_ff @(posedge sw_clk or posedge rst) begin
        if (rst) begin
            r_ebcd_prev    <= KEY_IDLE;
            r_state        <= S_A;
            r_a            <= '0;
            r_b            <= '0;
            r_op           <= OP_NONE;
            r_count        <= '0;
            r_fnd          <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_ebcd_prev    <= eBCD;
            r_result_valid <= 1'b0;
            if (w_key_event) begin
                if (eBCD == KEY_CLEAR) begin
                    r_state <= S_A;
                    r_a     <= '0;
                    r_b     <= '0;
                    r_op    <= OP_NONE;
                    r_count <= '0;
                    r_fnd   <= '0;
                end else begin
                    case (r_state)
                        S_A: begin
                            if (w_is_digit) begin
                                if (w_count_ok) begin
                                    r_a     <= w_acc;
                                    r_count <= w_acc_count;
                                    r_fnd   <= w_acc;
                                end
                            end else if (w_is_op) begin
                                r_op    <= w_key_op;
                                r_state <= S_OP;
                                r_fnd   <= op_disp(w_key_op);
                            end
                        end
                        S_OP: begin
                            if (w_is_digit) begin
                                r_b     <= w_digit;
                                r_count <= {{(CW-1){1'b0}}, w_digit_nz};
                                r_state <= S_B;
                                r_fnd   <= w_digit;
                            end else if (w_is_op) begin
                                r_op  <= w_key_op;
                                r_fnd <= op_disp(w_key_op);
                            end
                        end
                        S_B: begin
                            if (w_is_digit) begin
                                if (w_count_ok) begin
                                    r_b     <= w_acc;
                                    r_count <= w_acc_count;
                                    r_fnd   <= w_acc;
                                end
                            end else if (w_is_op || (eBCD == KEY_EQUAL)) begin
                                if (w_alu_err) begin
                                    r_state <= S_ERR;
                                    r_fnd   <= DISP_ERR;
                                end else begin
                                    r_a            <= w_alu_r;
                                    r_result_valid <= 1'b1;
                                    if (w_is_op) begin
                                        // Chained operator: result becomes A, new op pending
                                        r_op    <= w_key_op;
                                        r_state <= S_OP;
                                        r_fnd   <= op_disp(w_key_op);
                                    end else begin
                                        r_state <= S_RES;
                                        r_fnd   <= w_alu_r;
                                    end
                                end
                            end
                        end
                        S_RES: begin
                            if (w_is_digit) begin
                                r_a     <= w_digit;
                                r_count <= {{(CW-1){1'b0}}, w_digit_nz};
                                r_state <= S_A;
                                r_fnd   <= w_digit;
                            end else if (w_is_op) begin
                                r_op    <= w_key_op;
                                r_state <= S_OP;
                                r_fnd   <= op_disp(w_key_op);
                            end
                        end
                        S_ERR: begin
                            // Locked until CLEAR or reset
                            r_fnd <= DISP_ERR;
                        end
                        default: begin
                            r_state <= S_ERR;
                            r_fnd   <= DISP_ERR;
                        end
                    endcase
                end
            end
        end
    end

    assign fnd_serial   = r_fnd;
    assign result_valid = r_result_valid;
    assign err          = (r_state == S_ERR);
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_key_entry_fsm.sv
module tb_key_entry_fsm;
  import key_entry_fsm_pkg::*;

  // ---------------- clock / reset ----------------
  logic        sw_clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  eBCD = 5'h1F;
  logic [31:0] fnd_serial;
  logic        result_valid;
  logic        err;
  logic [2:0]  o_dbg_state;

  always #5 sw_clk = ~sw_clk;

  key_entry_fsm dut (
    .sw_clk       (sw_clk),
    .rst          (rst),
    .eBCD         (eBCD),
    .fnd_serial   (fnd_serial),
    .result_valid (result_valid),
    .err          (err),
    .o_dbg_state  (o_dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int rv_seen = 0;

  // expected {err, result_valid, fnd_serial} after each key press
  logic [33:0] exp_q[$];

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 entering A, 1 operator shown, 2 entering B, 3 result shown, 4 error
  int     m_mode;
  longint m_a, m_b, m_disp;
  int     m_op;

  function automatic int ndig(input longint x);
    int n = 0;
    longint v = (x < 0) ? -x : x;
    while (v > 0) begin
      n++;
      v = v / 10;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_a = 0; m_b = 0; m_op = 0; m_disp = 0;
  endtask

  task automatic model_calc(output longint r, output bit bad);
    bad = 0;
    r = 0;
    case (m_op)
      1: r = m_a + m_b;
      2: r = m_a - m_b;
      3: r = m_a * m_b;
      4: if (m_b == 0) bad = 1; else r = m_a / m_b;
      5: if (m_b == 0) bad = 1; else r = m_a % m_b;
      default: r = 0;
    endcase
    if (r > 999999 || r < -99999) bad = 1;
  endtask

  task automatic model_key(input logic [4:0] k, output logic [33:0] e);
    int     kv = int'(k);
    logic   rv = 1'b0;
    longint r;
    bit     bad;
    if (kv == 16) begin
      model_reset();
    end else if (m_mode == 4) begin
      m_disp = 32'h00EE_0000;
    end else if (kv <= 9) begin
      case (m_mode)
        0: begin if (ndig(m_a) < 5) m_a = m_a * 10 + kv; m_disp = m_a; end
        1: begin m_b = kv; m_mode = 2; m_disp = m_b; end
        2: begin if (ndig(m_b) < 5) m_b = m_b * 10 + kv; m_disp = m_b; end
        default: begin m_a = kv; m_mode = 0; m_disp = m_a; end
      endcase
    end else if (kv >= 10 && kv <= 14) begin
      if (m_mode == 2) begin
        model_calc(r, bad);
        if (bad) begin
          m_mode = 4; m_disp = 32'h00EE_0000;
        end else begin
          m_a = r; rv = 1'b1;
          m_op = kv - 9; m_mode = 1; m_disp = longint'(m_op) << 20;
        end
      end else begin
        m_op = kv - 9; m_mode = 1; m_disp = longint'(m_op) << 20;
      end
    end else if (kv == 15) begin
      if (m_mode == 2) begin
        model_calc(r, bad);
        if (bad) begin
          m_mode = 4; m_disp = 32'h00EE_0000;
        end else begin
          m_a = r; m_disp = r; rv = 1'b1; m_mode = 3;
        end
      end
    end
    e = {(m_mode == 4), rv, m_disp[31:0]};
  endtask

  // ---------------- monitor ----------------
  logic [4:0]  tb_prev;
  logic        tb_ev;
  logic [33:0] mon_e;

  always @(posedge sw_clk or posedge rst) begin
    if (rst) begin
      tb_prev <= 5'h1F;
      tb_ev   <= 1'b0;
    end else begin
      tb_ev   <= (tb_prev == 5'h1F) && (eBCD != 5'h1F);
      tb_prev <= eBCD;
    end
  end

  always @(negedge sw_clk) begin
    if (!rst) begin
      if (result_valid === 1'b1) rv_seen++;
      if (tb_ev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL key_resp no expected entry, actual=%h", {err, result_valid, fnd_serial});
        end else begin
          mon_e = exp_q.pop_front();
          chk("key_resp", {err, result_valid, fnd_serial}, mon_e);
        end
      end else begin
        chk("rv_quiet", {33'd0, result_valid}, 34'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press(input logic [4:0] k, input int hold);
    logic [33:0] e;
    @(negedge sw_clk);
    eBCD = k;
    model_key(k, e);
    exp_q.push_back(e);
    repeat (hold) @(negedge sw_clk);
    eBCD = 5'h1F;
  endtask

  task automatic press_num(input int n);
    int digs[$];
    int v = n;
    if (v == 0) digs.push_front(0);
    while (v > 0) begin
      digs.push_front(v % 10);
      v = v / 10;
    end
    foreach (digs[i]) press(5'(digs[i]), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge sw_clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    drain();
    @(negedge sw_clk);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_fnd", {2'b00, fnd_serial}, 34'd0);
    chk("rst_err_rv", {32'd0, err, result_valid}, 34'd0);
    chk("rst_state", {31'd0, o_dbg_state}, {31'd0, S_A});
    @(negedge sw_clk);
    rst = 1'b0;
  endtask

  task automatic expect_disp(input string name, input logic [31:0] v);
    chk(name, {2'b00, fnd_serial}, {2'b00, v});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    int rv_before;
    logic [4:0] k;
    do_reset();

    // 1: reset mid-entry
    press(5'd4, 1); press(5'd5, 1);
    do_reset();
    press(5'd7, 1);
    expect_disp("tp1_after_rst", 32'd7);

    // 2: 123 + 45 = 168
    press(KEY_CLEAR, 1);
    drain();
    rv_before = rv_seen;
    press_num(123);
    press(KEY_PLUS, 1);
    expect_disp("tp2_plus", 32'h0010_0000);
    press_num(45);
    press(KEY_EQUAL, 1);
    expect_disp("tp2_result", 32'd168);
    drain();
    chk("tp2_rv_pulses", 34'(rv_seen - rv_before), 34'd1);

    // 3: 7 - 9 = -2, then * 3 = -6
    press(5'd7, 1); press(KEY_MINUS, 1); press(5'd9, 1); press(KEY_EQUAL, 1);
    expect_disp("tp3_neg", 32'hFFFF_FFFE);
    press(KEY_MUL, 1); press(5'd3, 1); press(KEY_EQUAL, 1);
    expect_disp("tp3_mul", 32'hFFFF_FFFA);

    // 4: divide by zero
    press(KEY_CLEAR, 1);
    press(5'd8, 1); press(KEY_DIV, 1); press(5'd0, 1); press(KEY_EQUAL, 1);
    expect_disp("tp4_err_disp", 32'h00EE_0000);
    chk("tp4_err", {33'd0, err}, 34'd1);
    press(5'd5, 1);
    expect_disp("tp4_locked", 32'h00EE_0000);
    press(KEY_CLEAR, 1);
    expect_disp("tp4_clear", 32'd0);
    chk("tp4_err_clr", {33'd0, err}, 34'd0);

    // 5: held key, digit limit, leading zeros
    press(5'd3, 10);
    expect_disp("tp5_hold", 32'd3);
    press(KEY_CLEAR, 1);
    for (int d = 1; d <= 6; d++) press(5'(d), 1);
    expect_disp("tp5_limit", 32'd12345);
    press(KEY_CLEAR, 1);
    press(5'd0, 1); press(5'd0, 1); press(5'd7, 1);
    expect_disp("tp5_lead0", 32'd7);

    // 6: chaining, modulo, range
    press(KEY_CLEAR, 1);
    press(5'd2, 1); press(KEY_PLUS, 1); press(5'd3, 1); press(KEY_MUL, 1);
    expect_disp("tp6_chain_op", 32'h0030_0000);
    press(5'd4, 1); press(KEY_EQUAL, 1);
    expect_disp("tp6_chain", 32'd20);
    press(KEY_CLEAR, 1);
    press_num(17); press(KEY_MOD, 1); press(5'd5, 1); press(KEY_EQUAL, 1);
    expect_disp("tp6_mod", 32'd2);
    press(KEY_CLEAR, 1);
    press_num(99999); press(KEY_MUL, 1); press_num(99999); press(KEY_EQUAL, 1);
    expect_disp("tp6_range", 32'h00EE_0000);
    press(KEY_CLEAR, 1);

    // randomized key stream against the model
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      k = 5'($urandom_range(0, 9));
      else if (r < 80) k = 5'($urandom_range(10, 14));
      else if (r < 90) k = KEY_EQUAL;
      else if (r < 94) k = KEY_CLEAR;
      else             k = 5'($urandom_range(17, 30));
      press(k, $urandom_range(1, 3));
      if (n % 137 == 136) do_reset();
    end

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_entry_fsm.md
Name: key_entry_fsm

Overview:
Calculator entry/evaluation core. Consumes the 5-bit eBCD key codes produced by keypad_driver and builds operands, operators and results. Drives the signed 32-bit fnd_serial word consumed by segment_driver. Sits between keypad_driver and segment_driver on the sw_clk domain.

Parameters:
MAX_DIGITS, 5, max operand digits accepted; further digits are ignored.
RES_MAX, 999999, largest displayable result.
RES_MIN, -99999, smallest displayable result.

Ports:
sw_clk  input  1  system clock (keypad clock from clock_divider).
rst  input  1  reset; asynchronous, active-high.
eBCD  input  5  key code from keypad_driver; 5'h1F = no key.
fnd_serial  output  32  signed display word to segment_driver.
result_valid  output  1  one-cycle pulse when a result is loaded on '=' or on a chained operator.
err  output  1  high while in S_ERR.

Behaviour:
- Key codes:
  - 0x00-0x09: digits.
  - 0x0A: PLUS. 0x0B: MINUS. 0x0C: MUL. 0x0D: DIV. 0x0E: MOD.
  - 0x0F: EQUAL. 0x10: CLEAR. 0x1F: idle.
  - Any other code is ignored.
- Key event: registered eBCD_prev == 5'h1F and eBCD != 5'h1F at a rising sw_clk.
  - State, operands and fnd_serial update on that same edge.
  - Latency: 1 cycle from eBCD change.
  - A held key produces exactly one event; the next event requires a return to 5'h1F.
  - eBCD_prev resets to 5'h1F.
- Display codes on fnd_serial:
  - Operators: PLUS 0x0010_0000, MINUS 0x0020_0000, MUL 0x0030_0000, DIV 0x0040_0000, MOD 0x0050_0000.
  - Error: 0x00EE_0000.
  - Numbers are two's-complement values.
- Reset values: state S_A, A=0, B=0, op=none, digit count 0, fnd_serial=0, result_valid=0, err=0.
- CLEAR in any state: same as reset, without async behaviour.
- S_A (entering A):
  - Digit: if count < MAX_DIGITS, A = A*10 + d; count increments unless A stays 0 (leading zeros). Display A.
  - Operator: latch op, go to S_OP, display op code.
  - EQUAL: ignored.
- S_OP:
  - Digit: B = d, count = (d != 0), go to S_B, display B.
  - Operator: replaces op and updates the display.
  - EQUAL: ignored.
- S_B:
  - Digit: accumulate into B as in S_A.
  - EQUAL: R = A op B; display R, A = R, pulse result_valid, go to S_RES.
  - Operator (chaining, strictly left-to-right, no precedence): R = A op B, A = R, latch the new op, pulse result_valid, display the op code, go to S_OP.
- S_RES:
  - Digit: A = d, count reset, go to S_A.
  - Operator: keep A, latch op, go to S_OP.
  - EQUAL: ignored.
- S_ERR:
  - Display 0x00EE_0000, err = 1.
  - Only CLEAR (or rst) exits.
- Arithmetic:
  - Operands held signed 32-bit; products computed at 40 bits.
  - DIV and MOD truncate toward zero; the MOD result takes the dividend's sign.
  - B == 0 with DIV or MOD goes to S_ERR.
  - R > RES_MAX or R < RES_MIN goes to S_ERR; result_valid is not pulsed.
- Simultaneous events: async rst dominates everything. Only one key event is possible per cycle.
- Reset mid-entry: all partial operands are discarded immediately.

Decomposition:
- Shared package/header (calc_defs): key code constants, display code constants (OP/ERR words), state encodings, RES_MAX/RES_MIN.
- One combinational sub-module, calc_alu:
  - Inputs: A, B, op.
  - Outputs: R, err_flag (div-by-zero or range).
- FSM, edge detection and digit accumulation stay in key_entry_fsm.

Test Plan:
1. Reset, then rst mid-entry (keys 4,5 then rst) -> fnd_serial = 0, state S_A, err = 0; next key 7 -> 7.
2. Keys 1,2,3,PLUS,4,5,EQUAL -> 123, 0x0010_0000, 4, 45, 168 with one result_valid pulse.
3. Keys 7,MINUS,9,EQUAL -> 0xFFFF_FFFE (-2). Then MUL,3,EQUAL -> -6.
4. Keys 8,DIV,0,EQUAL -> 0x00EE_0000, err = 1; digit 5 ignored; CLEAR -> 0, err = 0.
5. eBCD held at 3 for 10 cycles then idle -> single event (3). Digits 1..6 -> 12345, sixth ignored. Leading 0,0,7 -> 7.
6. Chaining and range:
   - 2,PLUS,3,MUL,4,EQUAL -> 0x0030_0000 after MUL, then 20.
   - 17,MOD,5,EQUAL -> 2.
   - 99999,MUL,99999,EQUAL -> 0x00EE_0000.
